// File: rtl/ifft_pe_pipe.sv
// Inverse radix-2 butterfly processing element.
// Recovers (X, Y) from a forward butterfly's (A, B*W) using a two-stage
// valid/ready pipeline: stage 1 forms c = b * conj(w), stage 2 forms
// (a + c) and (a - c), optionally halved with round-half-up.
module ifft_pe_pipe #(
  parameter int SCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [17:0] w_real,
  input  logic [17:0] w_imag,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic        out_last,
  output logic        ovf_flag,
  input  logic        ovf_clr
);

  // Q16 product back to 16 bits: round half up, wrap on overflow.
  function automatic logic [15:0] rnd(input logic [34:0] t);
    return t[31:16] + {15'd0, t[15]};
  endfunction

  // Halve a 17-bit sum with round half up; result kept at 17 bits so the
  // range can still be checked.
  function automatic logic [16:0] half_rnd(input logic [16:0] s);
    logic [17:0] t;
    t = {s[16], s} + 18'd1;
    return t[17:1];
  endfunction

  // True when a 17-bit signed value is representable in 16 bits.
  function automatic logic fits16(input logic [16:0] v);
    return (v[16] == v[15]);
  endfunction

  logic               s1_v_r;
  logic               s2_v_r;
  logic               en1_s;
  logic               en2_s;
  logic [31:0]        a_r;
  logic               last1_r;
  logic [15:0]        c_re_r;
  logic [15:0]        c_im_r;

  logic signed [34:0] br_s;
  logic signed [34:0] bi_s;
  logic signed [34:0] wr_s;
  logic signed [34:0] wi_s;
  logic signed [34:0] t_re_s;
  logic signed [34:0] t_im_s;

  logic [16:0]        sx_re_s;
  logic [16:0]        sx_im_s;
  logic [16:0]        sy_re_s;
  logic [16:0]        sy_im_s;
  logic [16:0]        rx_re_s;
  logic [16:0]        rx_im_s;
  logic [16:0]        ry_re_s;
  logic [16:0]        ry_im_s;
  logic               ovf_evt_s;

  assign en2_s     = !s2_v_r || out_ready;
  assign en1_s     = !s1_v_r || en2_s;
  assign in_ready  = en1_s;
  assign out_valid = s2_v_r;

  // Sign-extend operands to the 35-bit accumulation width.
  assign br_s   = 35'($signed(b_in[31:16]));
  assign bi_s   = 35'($signed(b_in[15:0]));
  assign wr_s   = 35'($signed(w_real));
  assign wi_s   = 35'($signed(w_imag));
  assign t_re_s = br_s * wr_s + bi_s * wi_s;
  assign t_im_s = bi_s * wr_s - br_s * wi_s;

  assign sx_re_s = {a_r[31], a_r[31:16]} + {c_re_r[15], c_re_r};
  assign sx_im_s = {a_r[15], a_r[15:0]}  + {c_im_r[15], c_im_r};
  assign sy_re_s = {a_r[31], a_r[31:16]} - {c_re_r[15], c_re_r};
  assign sy_im_s = {a_r[15], a_r[15:0]}  - {c_im_r[15], c_im_r};

  // Select halved or raw sums and flag any component out of 16-bit range.
  always_comb begin
    rx_re_s = sx_re_s;
    rx_im_s = sx_im_s;
    ry_re_s = sy_re_s;
    ry_im_s = sy_im_s;
    if (SCALE == 1) begin
      rx_re_s = half_rnd(sx_re_s);
      rx_im_s = half_rnd(sx_im_s);
      ry_re_s = half_rnd(sy_re_s);
      ry_im_s = half_rnd(sy_im_s);
    end else begin
      rx_re_s = sx_re_s;
      rx_im_s = sx_im_s;
      ry_re_s = sy_re_s;
      ry_im_s = sy_im_s;
    end
    ovf_evt_s = !(fits16(rx_re_s) && fits16(rx_im_s) &&
                  fits16(ry_re_s) && fits16(ry_im_s));
  end

  // Stage 1: capture a, last and the conjugate-twiddle product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_r  <= 1'b0;
      a_r     <= 32'd0;
      last1_r <= 1'b0;
      c_re_r  <= 16'd0;
      c_im_r  <= 16'd0;
    end else if (en1_s) begin
      s1_v_r  <= in_valid;
      a_r     <= a_in;
      last1_r <= in_last;
      c_re_r  <= rnd(t_re_s);
      c_im_r  <= rnd(t_im_s);
    end
  end

  // Stage 2: register the recovered pair; holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_r   <= 1'b0;
      x_out    <= 32'd0;
      y_out    <= 32'd0;
      out_last <= 1'b0;
    end else if (en2_s) begin
      s2_v_r   <= s1_v_r;
      x_out    <= {rx_re_s[15:0], rx_im_s[15:0]};
      y_out    <= {ry_re_s[15:0], ry_im_s[15:0]};
      out_last <= last1_r;
    end
  end

  // Sticky overflow; a set event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (en2_s && s1_v_r && ovf_evt_s) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifft_pe_pipe.sv
// Directed bench for ifft_pe_pipe: one SCALE=1 and one SCALE=0 instance
// share all inputs, so handshakes match and both arithmetic modes are seen.
module tb_ifft_pe_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        ovf_clr = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic [17:0] w_real = 18'd0;
  logic [17:0] w_imag = 18'd0;

  logic        in_ready1, out_valid1, out_last1, ovf1;
  logic [31:0] x1, y1;
  logic        in_ready0, out_valid0, out_last0, ovf0;
  logic [31:0] x0, y0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifft_pe_pipe #(.SCALE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a_in(a_in), .b_in(b_in), .w_real(w_real), .w_imag(w_imag),
    .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .x_out(x1), .y_out(y1), .out_last(out_last1), .ovf_flag(ovf1),
    .ovf_clr(ovf_clr)
  );

  ifft_pe_pipe #(.SCALE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a_in(a_in), .b_in(b_in), .w_real(w_real), .w_imag(w_imag),
    .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .x_out(x0), .y_out(y0), .out_last(out_last0), .ovf_flag(ovf0),
    .ovf_clr(ovf_clr)
  );

  function automatic logic [31:0] cx(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one beat at a negedge, let it transfer, then withdraw it.
  task automatic put(input logic [31:0] a, input logic [31:0] b,
                     input int wr, input int wi, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    w_real   = wr[17:0];
    w_imag   = wi[17:0];
    in_last  = last;
    #1;
    chk("put_in_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Streaming beat k (k = 0..7) for the back-pressure run.
  task automatic set_beat(input int k);
    int m;
    m = k + 1;
    in_valid = 1'b1;
    a_in     = cx(10 * m, -m);
    b_in     = cx(m, 0);
    w_real   = 18'd65536;
    w_imag   = 18'd0;
    in_last  = (k == 7);
  endtask

  // Hard stop if something never terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got, cyc, m;
    bit in_fire, stalled, saw_block;
    logic [31:0] hx, hy;
    logic hl;

    // ---------------- reset state ----------------
    #3 rst = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("rst_x_out", x1, 32'd0);
    chk("rst_y_out", y0, 32'd0);
    chk("rst_out_last", {31'd0, out_last0}, 32'd0);
    chk("rst_ovf", {30'd0, ovf1, ovf0}, 32'd0);
    chk("rst_in_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // ---------------- real twiddle ----------------
    put(cx(100, 0), cx(50, 0), 65536, 0, 1'b0);
    @(negedge clk);
    chk("lat1_out_valid", {31'd0, out_valid1}, 32'd0);
    @(negedge clk);
    chk("lat2_out_valid", {31'd0, out_valid1}, 32'd1);
    chk("w1_x_s1", x1, cx(75, 0));
    chk("w1_y_s1", y1, cx(25, 0));
    chk("w1_x_s0", x0, cx(150, 0));
    chk("w1_y_s0", y0, cx(50, 0));
    chk("w1_last", {31'd0, out_last1}, 32'd0);

    // ---------------- imaginary twiddle ----------------
    put(cx(0, 0), cx(0, 50), 0, 65536, 1'b0);
    repeat (2) @(negedge clk);
    chk("wj_x_s1", x1, cx(25, 0));
    chk("wj_y_s1", y1, cx(-25, 0));
    chk("wj_x_s0", x0, cx(50, 0));
    chk("wj_y_s0", y0, cx(-50, 0));

    // ---------------- output rounding ----------------
    put(cx(3, -3), cx(0, 0), 65536, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rnd_x_s1", x1, cx(2, -1));
    chk("rnd_y_s1", y1, cx(2, -1));
    chk("rnd_x_s0", x0, cx(3, -3));

    // ---------------- product rounding: +0.5 -> 1, -0.5 -> 0 ----------------
    put(cx(0, 0), cx(1, 0), 32768, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("prnd_pos_x_s0", x0, cx(1, 0));
    chk("prnd_pos_y_s0", y0, cx(-1, 0));
    chk("prnd_pos_y_s1", y1, cx(0, 0));
    put(cx(0, 0), cx(-1, 0), 32768, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("prnd_neg_x_s0", x0, cx(0, 0));

    // ---------------- diagonal twiddle (conjugate sign) ----------------
    put(cx(0, 0), cx(100, 200), 46341, 46341, 1'b0);
    repeat (2) @(negedge clk);
    chk("diag_x_s0", x0, cx(212, 71));
    chk("diag_y_s0", y0, cx(-212, -71));
    chk("no_ovf_yet", {31'd0, ovf0}, 32'd0);

    // ---------------- back-pressure stream ----------------
    sent = 0; got = 0; cyc = 0;
    in_fire = 1'b0; stalled = 1'b0; saw_block = 1'b0;
    hx = 32'd0; hy = 32'd0; hl = 1'b0;
    @(negedge clk);
    set_beat(0);
    out_ready = 1'b1;
    #1;
    while (got < 8 && cyc < 200) begin
      if (stalled) begin
        chk("bp_hold_x", x0, hx);
        chk("bp_hold_y", y0, hy);
        chk("bp_hold_last", {31'd0, out_last0}, {31'd0, hl});
      end
      if (!in_ready1) begin
        saw_block = 1'b1;
        chk("bp_blocked_inflight", 32'(sent - got), 32'd2);
      end
      if (out_valid0 && out_ready) begin
        m = got + 1;
        chk("bp_x", x0, cx(11 * m, -m));
        chk("bp_y", y0, cx(9 * m, -m));
        chk("bp_last", {31'd0, out_last0}, {31'd0, (got == 7)});
        got++;
      end
      stalled = out_valid0 && !out_ready;
      hx = x0; hy = y0; hl = out_last0;
      in_fire = in_valid && in_ready1;
      cyc++;
      @(negedge clk);
      if (in_fire) begin
        sent++;
        if (sent < 8) set_beat(sent);
        else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
      out_ready = ((cyc % 3) == 0);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_count", 32'(got), 32'd8);
    chk("bp_saw_block", {31'd0, saw_block}, 32'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_extra", {31'd0, out_valid0}, 32'd0);
    end

    // ---------------- overflow, sticky, clear ----------------
    put(cx(32767, 0), cx(1, 0), 65536, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("ovf_x_s0", x0, 32'h8000_0000);
    chk("ovf_y_s0", y0, cx(32766, 0));
    chk("ovf_x_s1", x1, cx(16384, 0));
    chk("ovf_flag_set", {31'd0, ovf0}, 32'd1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", {31'd0, ovf0}, 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, ovf0}, 32'd0);
    put(cx(32767, 0), cx(1, 0), 65536, 0, 1'b0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    chk("ovf_set_beats_clr", {31'd0, ovf0}, 32'd1);
    chk("ovf_beat_valid", {31'd0, out_valid0}, 32'd1);
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr_again", {31'd0, ovf0}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ovf_stale_stage", {31'd0, ovf0}, 32'd0);

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0;
    put(cx(1, 1), cx(0, 0), 65536, 0, 1'b0);
    put(cx(2, 2), cx(0, 0), 65536, 0, 1'b1);
    @(negedge clk);
    chk("full_out_valid", {31'd0, out_valid1}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready1}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
    chk("mid_rst_x", x1, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready1}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'd0, out_valid1}, 32'd0);
    end
    put(cx(5, 0), cx(4, 0), 65536, 0, 1'b0);
    @(negedge clk);
    chk("post_rst_lat1", {31'd0, out_valid1}, 32'd0);
    @(negedge clk);
    chk("post_rst_lat2", {31'd0, out_valid1}, 32'd1);
    chk("post_rst_x_s1", x1, cx(5, 0));
    chk("post_rst_y_s1", y1, cx(1, 0));
    chk("post_rst_x_s0", x0, cx(9, 0));
    chk("post_rst_last", {31'd0, out_last1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifft_pe_pipe.md
IFFT_PE_PIPE -- requirements
Module: ifft_pe_pipe

Interface
REQ-001 Parameter: SCALE, default 1, meaning 1 = outputs halved (exact inverse of the forward butterfly), 0 = no halving.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  input beat present.
REQ-005 Port: in_ready  output  1  block accepts the beat this cycle.
REQ-006 Port: a_in  input  32  forward sum term, packed {real[31:16], imag[15:0]}, two's complement.
REQ-007 Port: b_in  input  32  forward difference-times-twiddle term, same packing.
REQ-008 Port: w_real  input  18  signed twiddle real part; 1.0 = 65536.
REQ-009 Port: w_imag  input  18  signed twiddle imaginary part; same scale.
REQ-010 Port: in_last  input  1  marks the final beat of a frame.
REQ-011 Port: out_valid  output  1  output beat present.
REQ-012 Port: out_ready  input  1  downstream accepts the beat.
REQ-013 Port: x_out  output  32  recovered X, packed as a_in.
REQ-014 Port: y_out  output  32  recovered Y, packed as a_in.
REQ-015 Port: out_last  output  1  in_last delayed with its beat.
REQ-016 Port: ovf_flag  output  1  sticky overflow indicator.
REQ-017 Port: ovf_clr  input  1  synchronous clear of ovf_flag.

Function
REQ-018 Input transfer shall occur when in_valid && in_ready; output transfer shall occur when out_valid && out_ready.
REQ-019 The block shall be a two-stage pipeline with valid bits s1_v and s2_v, with en2 = !s2_v || out_ready, en1 = !s1_v || en2, and in_ready = en1 (combinational).
REQ-020 Stage 1 (loads on en1) shall register a_in, in_last, and c = b*conj(w): c_re = rnd(br*wr + bi*wi), c_im = rnd(bi*wr - br*wi).
REQ-021 In REQ-020, br and bi are the signed 16-bit halves of b_in, and each sum is formed at 35 bits from full signed 16x18 products.
REQ-022 rnd(t) shall be t[31:16] + t[15], truncated to 16 bits (round half up, wrap on overflow).
REQ-023 s1_v shall load in_valid && in_ready when en1 is high and hold otherwise.
REQ-024 Stage 2 (loads on en2) shall compute per component the 17-bit signed sums sx = a + c and sy = a - c.
REQ-025 With SCALE=1, stage 2 shall register x = (sx + 1) >>> 1 and y = (sy + 1) >>> 1 (arithmetic shift, 16-bit result).
REQ-026 With SCALE=0, stage 2 shall register x = sx[15:0] and y = sy[15:0].
REQ-027 s2_v shall load s1_v when en2 is high; out_last shall follow the beat.
REQ-028 Latency shall be exactly 2 cycles from input transfer to out_valid when out_ready is held high; throughput shall be 1 beat per cycle.
REQ-029 While out_valid && !out_ready, x_out, y_out and out_last shall hold stable; no beat shall be lost or duplicated under any ready pattern.
REQ-030 ovf_flag shall set on a stage-2 load of a valid beat where any 17-bit sum (or rounded sum, when SCALE=1) is outside [-32768, 32767].
REQ-031 If ovf_clr and a set event occur in the same cycle, ovf_flag shall be 1.
REQ-032 Register contents of invalid stages are don't-care, but they shall never set ovf_flag.

Reset
REQ-033 On rst asserted, s1_v, s2_v, out_valid, out_last and ovf_flag shall go to 0 and x_out, y_out to 0, immediately (asynchronously).
REQ-034 While rst is asserted, in_ready shall read 1.
REQ-035 Beats in flight when rst asserts shall be discarded.
REQ-036 The first beat accepted after rst deasserts shall emerge 2 cycles later.

Verification
REQ-037 SCALE=1, w=(65536,0), a_in=(100,0), b_in=(50,0), out_ready=1 -> 2 cycles later x_out=(75,0), y_out=(25,0).
REQ-038 SCALE=1, w=(0,65536), a_in=(0,0), b_in=(0,50) -> c=(50,0); x_out=(25,0), y_out=(-25,0).
REQ-039 Rounding: SCALE=1, a_in=(3,-3), b_in=0 -> x_out=y_out=(2,-1).
REQ-040 Back-pressure: stream 8 beats with out_ready toggling 1,0,0,1,... -> in_ready deasserts when both stages are full; outputs arrive in order, unchanged while stalled; out_last appears only on beat 8.
REQ-041 SCALE=0, a_in=(32767,0), b_in=(1,0), w=(65536,0) -> x_out=(-32768,0) and ovf_flag=1; ovf_flag=1 persists until ovf_clr, and is still 1 if ovf_clr coincides with a new overflow.
REQ-042 Assert rst mid-stream with both stages valid -> out_valid drops at once; after release no stale beats emerge.
